// File: rtl/msg_word_assembler_if.sv
// Bus between the serial message receiver and the word assembler.
// The receiver side (master) drives the byte stream and message flags.
// The assembler side (slave) drives the store writes and the status pulses.
interface msg_word_assembler_if #(
  parameter int WORD_BYTES = 4,
  parameter int ADDR_WIDTH = 8
) ();

  logic [7:0]              msg_in;
  logic                    data_valid;
  logic                    particle_data_flag;
  logic                    map_data_flag;

  logic                    wr_en;
  logic                    wr_sel;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [WORD_BYTES*8-1:0] wr_data;
  logic                    msg_done;
  logic                    msg_abort;
  logic [ADDR_WIDTH-1:0]   particle_count;

  modport master (
    output msg_in,
    output data_valid,
    output particle_data_flag,
    output map_data_flag,
    input  wr_en,
    input  wr_sel,
    input  wr_addr,
    input  wr_data,
    input  msg_done,
    input  msg_abort,
    input  particle_count
  );

  modport slave (
    input  msg_in,
    input  data_valid,
    input  particle_data_flag,
    input  map_data_flag,
    output wr_en,
    output wr_sel,
    output wr_addr,
    output wr_data,
    output msg_done,
    output msg_abort,
    output particle_count
  );

endinterface

// File: rtl/msg_word_assembler.sv
// Packs payload bytes from the serial message receiver big-endian into
// WORD_BYTES-wide words and writes them into either the particle store or
// the map store. Each store has its own circular word pointer; a message
// only advances its pointer once complete, and an aborted message rolls the
// pointer back so the next message overwrites the partial data.
module msg_word_assembler #(
  parameter int WORD_BYTES         = 4,
  parameter int PARTICLE_MSG_BYTES = 8,
  parameter int MAP_MSG_BYTES      = 16,
  parameter int PARTICLE_SLOTS     = 64,
  parameter int MAP_SLOTS          = 16,
  parameter int ADDR_WIDTH         = 8
) (
  input  logic clk,
  input  logic reset_n,
  msg_word_assembler_if.slave bus
);

  localparam int DATA_W        = WORD_BYTES * 8;
  localparam int MAX_MSG_BYTES = (PARTICLE_MSG_BYTES > MAP_MSG_BYTES) ?
                                 PARTICLE_MSG_BYTES : MAP_MSG_BYTES;
  localparam int CNT_W         = $clog2(MAX_MSG_BYTES + 1);
  localparam int BIW_W         = $clog2(WORD_BYTES + 1);

  // Last valid word address of each store, and last particle count value.
  localparam logic [ADDR_WIDTH-1:0] PART_LAST  =
    ADDR_WIDTH'(PARTICLE_SLOTS * PARTICLE_MSG_BYTES / WORD_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] MAP_LAST   =
    ADDR_WIDTH'(MAP_SLOTS * MAP_MSG_BYTES / WORD_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] COUNT_LAST = ADDR_WIDTH'(PARTICLE_SLOTS - 1);

  localparam logic [CNT_W-1:0] PART_LEN = CNT_W'(PARTICLE_MSG_BYTES);
  localparam logic [CNT_W-1:0] MAP_LEN  = CNT_W'(MAP_MSG_BYTES);
  localparam logic [BIW_W-1:0] WORD_LEN = BIW_W'(WORD_BYTES);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  // Message type encoding matches wr_sel: 0 = particle, 1 = map.
  logic [0:0]            state;
  logic                  dv_q;
  logic                  msg_type;
  logic [DATA_W-1:0]     word;
  logic [BIW_W-1:0]      byte_in_word;
  logic [CNT_W-1:0]      byte_cnt;
  logic [ADDR_WIDTH-1:0] part_ptr;
  logic [ADDR_WIDTH-1:0] map_ptr;
  logic [ADDR_WIDTH-1:0] start_ptr;

  logic                  wr_en_q;
  logic                  wr_sel_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_W-1:0]     wr_data_q;
  logic                  msg_done_q;
  logic                  msg_abort_q;
  logic [ADDR_WIDTH-1:0] particle_count_q;

  logic                  accept;
  logic                  one_flag;
  logic                  cur_type;
  logic [DATA_W-1:0]     base_word;
  logic [DATA_W-1:0]     shifted_word;
  logic [BIW_W-1:0]      biw_next;
  logic [CNT_W-1:0]      cnt_next;
  logic                  word_full;
  logic                  msg_full;
  logic [ADDR_WIDTH-1:0] cur_ptr;
  logic [ADDR_WIDTH-1:0] ptr_next;
  logic                  abort_collect;

  // Decode the byte edge, the abort condition and what the current byte does.
  always_comb begin
    accept        = bus.data_valid & ~dv_q;
    one_flag      = bus.particle_data_flag ^ bus.map_data_flag;
    cur_type      = (state == IDLE) ? bus.map_data_flag : msg_type;
    base_word     = (state == IDLE) ? '0 : word;
    shifted_word  = (base_word << 8) | DATA_W'(bus.msg_in);
    biw_next      = ((state == IDLE) ? '0 : byte_in_word) + BIW_W'(1);
    cnt_next      = ((state == IDLE) ? '0 : byte_cnt) + CNT_W'(1);
    word_full     = (biw_next == WORD_LEN);
    msg_full      = (cnt_next == (cur_type ? MAP_LEN : PART_LEN));
    cur_ptr       = cur_type ? map_ptr : part_ptr;
    ptr_next      = (cur_ptr == (cur_type ? MAP_LAST : PART_LAST)) ?
                    '0 : cur_ptr + ADDR_WIDTH'(1);
    abort_collect = 1'b0;
    if (state == COLLECT) begin
      if (msg_type)
        abort_collect = ~bus.map_data_flag | bus.particle_data_flag;
      else
        abort_collect = ~bus.particle_data_flag | bus.map_data_flag;
    end
  end

  // Message state, pointers, word packing and registered write/status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      dv_q             <= 1'b0;
      msg_type         <= 1'b0;
      word             <= '0;
      byte_in_word     <= '0;
      byte_cnt         <= '0;
      part_ptr         <= '0;
      map_ptr          <= '0;
      start_ptr        <= '0;
      wr_en_q          <= 1'b0;
      wr_sel_q         <= 1'b0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
      msg_done_q       <= 1'b0;
      msg_abort_q      <= 1'b0;
      particle_count_q <= '0;
    end else begin
      dv_q        <= bus.data_valid;
      wr_en_q     <= 1'b0;
      msg_done_q  <= 1'b0;
      msg_abort_q <= 1'b0;

      if (abort_collect) begin
        msg_abort_q  <= 1'b1;
        if (msg_type)
          map_ptr <= start_ptr;
        else
          part_ptr <= start_ptr;
        word         <= '0;
        byte_in_word <= '0;
        byte_cnt     <= '0;
        state        <= IDLE;
      end else if (accept) begin
        if ((state == IDLE) && !one_flag) begin
          msg_abort_q <= 1'b1;
        end else begin
          if (state == IDLE) begin
            msg_type  <= cur_type;
            start_ptr <= cur_ptr;
            state     <= COLLECT;
          end
          byte_cnt <= cnt_next;

          if (word_full) begin
            wr_en_q      <= 1'b1;
            wr_sel_q     <= cur_type;
            wr_addr_q    <= cur_ptr;
            wr_data_q    <= shifted_word;
            word         <= '0;
            byte_in_word <= '0;
            if (cur_type)
              map_ptr <= ptr_next;
            else
              part_ptr <= ptr_next;
          end else begin
            word         <= shifted_word;
            byte_in_word <= biw_next;
          end

          if (msg_full) begin
            msg_done_q <= 1'b1;
            byte_cnt   <= '0;
            state      <= IDLE;
            if (!cur_type)
              particle_count_q <= (particle_count_q == COUNT_LAST) ?
                                  '0 : particle_count_q + ADDR_WIDTH'(1);
          end
        end
      end
    end
  end

  assign bus.wr_en          = wr_en_q;
  assign bus.wr_sel         = wr_sel_q;
  assign bus.wr_addr        = wr_addr_q;
  assign bus.wr_data        = wr_data_q;
  assign bus.msg_done       = msg_done_q;
  assign bus.msg_abort      = msg_abort_q;
  assign bus.particle_count = particle_count_q;

endmodule

// File: tb/tb_msg_word_assembler.sv
// Self-checking bench for msg_word_assembler. A message-level model predicts
// every write and status pulse; a compare process checks the DUT against it
// each cycle, and directed scenarios pin results to hand-computed literals.
module tb_msg_word_assembler;

  localparam int WB          = 4;
  localparam int AW          = 8;
  localparam int PART_BYTES  = 8;
  localparam int MAP_BYTES   = 16;
  localparam int PART_SLOTS  = 64;
  localparam int MAP_SLOTS   = 16;
  localparam int PART_WORDS  = PART_SLOTS * PART_BYTES / WB;
  localparam int MAP_WORDS   = MAP_SLOTS * MAP_BYTES / WB;

  typedef struct {
    logic          sel;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          done;
  } wr_rec_t;

  logic clk;
  logic reset_n;

  msg_word_assembler_if #(.WORD_BYTES(WB), .ADDR_WIDTH(AW)) bus ();

  msg_word_assembler #(
    .WORD_BYTES(WB),
    .PARTICLE_MSG_BYTES(PART_BYTES),
    .MAP_MSG_BYTES(MAP_BYTES),
    .PARTICLE_SLOTS(PART_SLOTS),
    .MAP_SLOTS(MAP_SLOTS),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int assert_count = 0;
  int fail_count   = 0;

  wr_rec_t obs[$];
  int      done_cnt  = 0;
  int      abort_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Message-level reference model
  logic        m_prev_dv;
  bit          m_active;
  bit          m_type;
  int          m_base;
  logic [7:0]  m_bytes[$];
  int          m_ptr[2];
  int          m_count;
  int          m_n;
  logic [31:0] m_word;
  bit          m_accept;
  logic        exp_wr_en, exp_sel, exp_done, exp_abort;
  int          exp_addr;
  logic [31:0] exp_data;

  function automatic int limit_of(input bit t);
    return t ? MAP_WORDS : PART_WORDS;
  endfunction

  function automatic int len_of(input bit t);
    return t ? MAP_BYTES : PART_BYTES;
  endfunction

  // Model: predicts the outputs visible in the cycle after each clock edge
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_prev_dv = 1'b0;
      m_active  = 0;
      m_type    = 0;
      m_base    = 0;
      m_bytes.delete();
      m_ptr[0]  = 0;
      m_ptr[1]  = 0;
      m_count   = 0;
      exp_wr_en = 0; exp_sel = 0; exp_done = 0; exp_abort = 0;
      exp_addr  = 0; exp_data = '0;
    end else begin
      m_accept  = bus.data_valid && !m_prev_dv;
      m_prev_dv = bus.data_valid;
      exp_wr_en = 0; exp_done = 0; exp_abort = 0;
      if (m_active && (m_type ? (!bus.map_data_flag || bus.particle_data_flag)
                              : (!bus.particle_data_flag || bus.map_data_flag))) begin
        exp_abort = 1;
        m_active  = 0;
      end else if (m_accept) begin
        if (!m_active) begin
          if (bus.particle_data_flag ^ bus.map_data_flag) begin
            m_active = 1;
            m_type   = bus.map_data_flag;
            m_base   = m_ptr[m_type];
            m_bytes.delete();
          end else begin
            exp_abort = 1;
          end
        end
        if (m_active) begin
          m_bytes.push_back(bus.msg_in);
          m_n = m_bytes.size();
          if (m_n % WB == 0) begin
            m_word = '0;
            for (int k = m_n - WB; k < m_n; k++) m_word = (m_word << 8) | 32'(m_bytes[k]);
            exp_wr_en = 1;
            exp_sel   = m_type;
            exp_addr  = (m_base + m_n / WB - 1) % limit_of(m_type);
            exp_data  = m_word;
          end
          if (m_n == len_of(m_type)) begin
            exp_done       = 1;
            m_ptr[m_type]  = (m_base + len_of(m_type) / WB) % limit_of(m_type);
            if (!m_type) m_count = (m_count + 1) % PART_SLOTS;
            m_active = 0;
          end
        end
      end
    end
  end

  // Compare DUT outputs against the model every cycle and log observed writes
  always @(negedge clk) begin
    check_output("wr_en", 64'(bus.wr_en), 64'(exp_wr_en));
    check_output("msg_done", 64'(bus.msg_done), 64'(exp_done));
    check_output("msg_abort", 64'(bus.msg_abort), 64'(exp_abort));
    check_output("particle_count", 64'(bus.particle_count), 64'(m_count));
    if (exp_wr_en) begin
      check_output("wr_sel", 64'(bus.wr_sel), 64'(exp_sel));
      check_output("wr_addr", 64'(bus.wr_addr), 64'(exp_addr));
      check_output("wr_data", 64'(bus.wr_data), 64'(exp_data));
    end
    if (bus.wr_en === 1'b1)
      obs.push_back('{sel: bus.wr_sel, addr: bus.wr_addr, data: bus.wr_data, done: bus.msg_done});
    if (bus.msg_done === 1'b1) done_cnt++;
    if (bus.msg_abort === 1'b1) abort_cnt++;
  end

  task automatic apply_stimulus(input logic [7:0] b, input int hold);
    @(negedge clk);
    bus.msg_in     = b;
    bus.data_valid = 1'b1;
    repeat (hold) @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  task automatic send_msg(input bit typ, input logic [7:0] first, input int n,
                          input int hold, input bit drop_flags);
    @(negedge clk);
    bus.particle_data_flag = !typ;
    bus.map_data_flag      = typ;
    for (int i = 0; i < n; i++) apply_stimulus(first + 8'(i), hold);
    if (drop_flags) begin
      @(negedge clk);
      bus.particle_data_flag = 1'b0;
      bus.map_data_flag      = 1'b0;
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    @(posedge clk);
    obs.delete();
    done_cnt  = 0;
    abort_cnt = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_output({tag, "_wr_en"}, 64'(bus.wr_en), 64'd0);
    check_output({tag, "_wr_sel"}, 64'(bus.wr_sel), 64'd0);
    check_output({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
    check_output({tag, "_wr_data"}, 64'(bus.wr_data), 64'd0);
    check_output({tag, "_msg_done"}, 64'(bus.msg_done), 64'd0);
    check_output({tag, "_msg_abort"}, 64'(bus.msg_abort), 64'd0);
    check_output({tag, "_particle_count"}, 64'(bus.particle_count), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_zero_outputs("rst");
    @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    reset_n                = 1'b0;
    bus.msg_in             = '0;
    bus.data_valid         = 1'b0;
    bus.particle_data_flag = 1'b0;
    bus.map_data_flag      = 1'b0;
    #1 check_zero_outputs("reset_state");
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;

    // 1: particle message, data_valid held 3 cycles per byte
    clear_log();
    send_msg(1'b0, 8'h11, 8, 3, 1'b1);
    settle();
    check_output("t1_nwr", 64'(obs.size()), 64'd2);
    check_output("t1_sel0", 64'(obs[0].sel), 64'd0);
    check_output("t1_addr0", 64'(obs[0].addr), 64'd0);
    check_output("t1_data0", 64'(obs[0].data), 64'h11121314);
    check_output("t1_done0", 64'(obs[0].done), 64'd0);
    check_output("t1_addr1", 64'(obs[1].addr), 64'd1);
    check_output("t1_data1", 64'(obs[1].data), 64'h15161718);
    check_output("t1_done1", 64'(obs[1].done), 64'd1);
    check_output("t1_count", 64'(bus.particle_count), 64'd1);

    // 2: map message
    clear_log();
    send_msg(1'b1, 8'hA0, 16, 1, 1'b1);
    settle();
    check_output("t2_nwr", 64'(obs.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_output("t2_sel", 64'(obs[i].sel), 64'd1);
      check_output("t2_addr", 64'(obs[i].addr), 64'(i));
    end
    check_output("t2_last_data", 64'(obs[3].data), 64'hACADAEAF);
    check_output("t2_count", 64'(bus.particle_count), 64'd1);

    // 3: particle flag drops after 5 bytes, then a full particle message
    do_reset();
    clear_log();
    send_msg(1'b0, 8'h31, 5, 1, 1'b1);
    settle();
    check_output("t3_nwr_abort", 64'(obs.size()), 64'd1);
    check_output("t3_addr_abort", 64'(obs[0].addr), 64'd0);
    check_output("t3_data_abort", 64'(obs[0].data), 64'h31323334);
    check_output("t3_abort_cnt", 64'(abort_cnt), 64'd1);
    check_output("t3_done_cnt", 64'(done_cnt), 64'd0);
    clear_log();
    send_msg(1'b0, 8'h41, 8, 2, 1'b1);
    settle();
    check_output("t3_nwr", 64'(obs.size()), 64'd2);
    check_output("t3_addr0", 64'(obs[0].addr), 64'd0);
    check_output("t3_data0", 64'(obs[0].data), 64'h41424344);
    check_output("t3_addr1", 64'(obs[1].addr), 64'd1);
    check_output("t3_count", 64'(bus.particle_count), 64'd1);

    // 4: 64 particle messages then one more, pointer and count wrap
    do_reset();
    clear_log();
    for (int m = 0; m < 64; m++) send_msg(1'b0, 8'(m * 3), 8, 1, 1'b1);
    settle();
    check_output("t4_count64", 64'(bus.particle_count), 64'd0);
    check_output("t4_last_addr", 64'(obs[127].addr), 64'd127);
    send_msg(1'b0, 8'hE0, 8, 1, 1'b1);
    settle();
    check_output("t4_nwr", 64'(obs.size()), 64'd130);
    check_output("t4_wrap_addr0", 64'(obs[128].addr), 64'd0);
    check_output("t4_wrap_addr1", 64'(obs[129].addr), 64'd1);
    check_output("t4_wrap_data1", 64'(obs[129].data), 64'hE4E5E6E7);
    check_output("t4_count65", 64'(bus.particle_count), 64'd1);
    check_output("t4_done_cnt", 64'(done_cnt), 64'd65);

    // 5: byte with both flags high in idle, then a normal message
    clear_log();
    @(negedge clk);
    bus.particle_data_flag = 1'b1;
    bus.map_data_flag      = 1'b1;
    apply_stimulus(8'h77, 1);
    @(negedge clk);
    bus.particle_data_flag = 1'b0;
    bus.map_data_flag      = 1'b0;
    settle();
    check_output("t5_nwr_bad", 64'(obs.size()), 64'd0);
    check_output("t5_abort_cnt", 64'(abort_cnt), 64'd1);
    send_msg(1'b0, 8'h51, 8, 1, 1'b1);
    settle();
    check_output("t5_nwr", 64'(obs.size()), 64'd2);
    check_output("t5_addr0", 64'(obs[0].addr), 64'd2);
    check_output("t5_data1", 64'(obs[1].data), 64'h55565758);
    check_output("t5_count", 64'(bus.particle_count), 64'd2);

    // 6: reset in the middle of a map message
    clear_log();
    send_msg(1'b1, 8'hB0, 6, 1, 1'b0);
    settle();
    check_output("t6_pre_data", 64'(obs[0].data), 64'hB0B1B2B3);
    do_reset();
    @(negedge clk);
    bus.particle_data_flag = 1'b0;
    bus.map_data_flag      = 1'b0;
    settle();
    check_output("t6_abort_cnt", 64'(abort_cnt), 64'd0);
    clear_log();
    send_msg(1'b1, 8'hC0, 16, 1, 1'b1);
    settle();
    check_output("t6_nwr", 64'(obs.size()), 64'd4);
    check_output("t6_addr0", 64'(obs[0].addr), 64'd0);
    check_output("t6_data0", 64'(obs[0].data), 64'hC0C1C2C3);
    check_output("t6_count", 64'(bus.particle_count), 64'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/msg_word_assembler.md
Name: msg_word_assembler

Overview:
- Sits directly downstream of the serial message receiver. Consumes its byte stream (msg_out/data_valid) and message-type flags (particle_data_flag/map_data_flag).
- Packs payload bytes big-endian into WORD_BYTES-wide words and issues single-cycle writes into the particle store or the map store.
- Maintains a separate circular write pointer per store, commits a message only when it is complete, and rolls back aborted messages.

Parameters:
- WORD_BYTES, 4, bytes per output word (1..8).
- PARTICLE_MSG_BYTES, 8, payload bytes per particle message; must be a multiple of WORD_BYTES.
- MAP_MSG_BYTES, 16, payload bytes per map message; must be a multiple of WORD_BYTES.
- PARTICLE_SLOTS, 64, number of particle messages held in the particle store before the pointer wraps.
- MAP_SLOTS, 16, number of map messages held in the map store before the pointer wraps.
- ADDR_WIDTH, 8, width of wr_addr; must cover PARTICLE_SLOTS*PARTICLE_MSG_BYTES/WORD_BYTES and MAP_SLOTS*MAP_MSG_BYTES/WORD_BYTES.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- msg_in  in  8  payload byte from the receiver.
- data_valid  in  1  level; high for one or more cycles per byte.
- particle_data_flag  in  1  high while a particle message is in progress.
- map_data_flag  in  1  high while a map message is in progress.
- wr_en  out  1  single-cycle write strobe.
- wr_sel  out  1  0 = particle store, 1 = map store.
- wr_addr  out  ADDR_WIDTH  word address within the selected store.
- wr_data  out  WORD_BYTES*8  packed word; first received byte in the MSBs.
- msg_done  out  1  one-cycle pulse when a message is committed.
- msg_abort  out  1  one-cycle pulse when a message is discarded.
- particle_count  out  ADDR_WIDTH  committed particle messages, wrapping at PARTICLE_SLOTS.

Behaviour:
- Reset: async, active-low. All outputs 0, both pointers 0, shift register 0, state IDLE.
- Byte accept:
  - A byte is accepted only on the rising edge of data_valid (data_valid=1 and the registered previous value=0).
  - A level held for N cycles yields exactly one byte.
- State IDLE:
  - Accepted byte with exactly one flag high: latch the message type, shift the byte in, byte_cnt=1, latch start_ptr from that type's pointer, go to COLLECT.
  - Accepted byte with neither flag or both flags high: drop the byte, pulse msg_abort, stay in IDLE.
- State COLLECT:
  - Each accepted byte is shifted into the word: word = {word[N-9:0], byte}.
  - When byte_in_word reaches WORD_BYTES, the next cycle drives wr_en=1, wr_sel=type, wr_addr=ptr, wr_data=word; then ptr increments and byte_in_word clears.
  - Write latency: 1 cycle from the accepting clock edge.
- Completion:
  - When byte_cnt reaches the type's MSG_BYTES, msg_done is asserted in the same cycle as the final wr_en.
  - On completion the pointer stays advanced, particle_count increments for particle messages only, and the state returns to IDLE.
- Abort (checked every cycle in COLLECT, priority over byte accept):
  - Trigger: the latched type's flag goes low, or the other type's flag goes high.
  - Response: pulse msg_abort, restore the type's ptr to start_ptr, discard the partial word, go to IDLE. No further wr_en for that message.
  - Words already written stay in memory but are overwritten by the next message.
  - A byte edge in the abort cycle is dropped.
- Pointer wrap:
  - Particle ptr wraps from PARTICLE_SLOTS*PARTICLE_MSG_BYTES/WORD_BYTES-1 to 0.
  - Map ptr wraps at its own limit.
  - The two pointers are independent.
- Back-to-back messages: a byte accepted in the cycle after msg_done is handled by IDLE normally; no dead cycle is required beyond the one-cycle registered write.
- Reset mid-message: everything clears immediately, with no msg_abort pulse.

Test Plan:
1. Particle message, bytes 0x11..0x18, data_valid held 3 cycles per byte → wr_en twice, sel=0, addr 0 then 1, data 0x11121314 then 0x15161718; msg_done coincident with the second write; particle_count=1.
2. Map message, 16 bytes 0xA0..0xAF → 4 writes, sel=1, addr 0..3, last data 0xACADAEAF; particle_count unchanged.
3. Particle flag drops after 5 bytes → one write at addr 0, msg_abort pulse, no msg_done; next full particle message writes again at addr 0 and 1.
4. 64 complete particle messages followed by one more → the 65th writes at addr 0 and 1; particle_count wraps to 1.
5. data_valid edge with both flags high in IDLE → no write, msg_abort pulse; the next valid message proceeds normally.
6. reset_n asserted low after 6 bytes of a map message → outputs 0 immediately; after release, a new map message writes starting at addr 0.
